// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - extension op codes shared by the ext stage and its core
package ext_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    EXT_UE  = 3'b000,
    EXT_SE  = 3'b001,
    EXT_HE  = 3'b010,
    EXT_LBU = 3'b011,
    EXT_LB  = 3'b100,
    EXT_LHU = 3'b101,
    EXT_LH  = 3'b110,
    EXT_RSV = 3'b111
  } ext_op_e;

endpackage

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational immediate / load-lane extension
module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_W = 16,
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [OP_W-1:0]   op,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] ext_data,
  output logic              ext_err
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Lane muxes use constant slices only; the halfword lane ignores off[0].
  always_comb begin
    lane_b = '0;
    lane_h = '0;
    for (int i = 0; i < DATA_W / 8; i++) begin
      if (off == OFF_W'(i)) lane_b = data[8*i +: 8];
    end
    for (int i = 0; i < DATA_W / 16; i++) begin
      if ((off >> 1) == OFF_W'(i)) lane_h = data[16*i +: 16];
    end
  end

  always_comb begin
    ext_data = '0;
    ext_err  = 1'b0;
    case (ext_op_e'(op))
      EXT_UE:  ext_data = {{(DATA_W-IMM_W){1'b0}}, imm};
      EXT_SE:  ext_data = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      EXT_HE:  ext_data = {imm, {(DATA_W-IMM_W){1'b0}}};
      EXT_LBU: ext_data = {{(DATA_W-8){1'b0}}, lane_b};
      EXT_LB:  ext_data = {{(DATA_W-8){lane_b[7]}}, lane_b};
      EXT_LHU: begin
        if (off[0]) ext_err = 1'b1;
        else        ext_data = {{(DATA_W-16){1'b0}}, lane_h};
      end
      EXT_LH: begin
        if (off[0]) ext_err = 1'b1;
        else        ext_data = {{(DATA_W-16){lane_h[15]}}, lane_h};
      end
      default: ext_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ext_stage.sv
// rtl/ext_stage.sv - one-cycle extension stage with skid buffer and error counter
module ext_stage
  import ext_pkg::*;
#(
  parameter int IMM_W = 16,
  parameter int DATA_W = 32,
  parameter int CNT_W = 16,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt
);

  logic [DATA_W-1:0] core_data;
  logic              core_err;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              skid_err;
  logic              accept;
  logic              deliver;

  ext_core #(.IMM_W(IMM_W), .DATA_W(DATA_W)) u_core (
    .op       (in_op),
    .imm      (in_imm),
    .data     (in_data),
    .off      (in_off),
    .ext_data (core_data),
    .ext_err  (core_err)
  );

  // in_ready comes straight from a flop so out_ready never reaches it.
  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign deliver  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (deliver && out_err && (err_cnt != {CNT_W{1'b1}}))
        err_cnt <= err_cnt + 1'b1;
      if (flush) begin
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
        // A full skid blocks acceptance, so it is drained before new beats.
        if (skid_valid) begin
          out_data   <= skid_data;
          out_err    <= skid_err;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_data  <= core_data;
          out_err   <= core_err;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= core_data;
        skid_err   <= core_err;
      end
    end
  end

endmodule

// File: tb/tb_ext_stage.sv
// tb/tb_ext_stage.sv - self-checking bench for ext_stage against a queue model
module tb_ext_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [2:0]  in_op;
  logic [15:0] in_imm;
  logic [31:0] in_data;
  logic [1:0]  in_off;
  logic        in_ready, out_valid, out_err;
  logic [31:0] out_data;
  logic [15:0] err_cnt;
  logic        in_ready_s, out_valid_s, out_err_s;
  logic [31:0] out_data_s;
  logic [1:0]  err_cnt_s;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } beat_t;

  beat_t q[$];
  beat_t nb;
  bit    acc, del;
  int    ecnt = 0;
  int    n_deliv = 0;
  bit    chk_en = 0;
  int    n_cmp = 0;
  int    n_bad = 0;

  always #5 clk = ~clk;

  ext_stage #(.IMM_W(16), .DATA_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_imm(in_imm),
    .in_data(in_data), .in_off(in_off),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  ext_stage #(.IMM_W(16), .DATA_W(32), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_op(in_op), .in_imm(in_imm),
    .in_data(in_data), .in_off(in_off),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_err(out_err_s), .err_cnt(err_cnt_s)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Arithmetic reference: select lanes by division, sign-extend by subtraction.
  function automatic beat_t ref_ext(int op, int imm, longint d, int off);
    beat_t  r;
    longint b, h, v;
    b = (d >> (8 * off)) % 256;
    h = (d >> (8 * off)) % 65536;
    case (op)
      0: v = imm;
      1: v = (imm >= 32768) ? imm - 65536 : imm;
      2: v = imm * 65536;
      3: v = b;
      4: v = (b >= 128) ? b - 256 : b;
      5: v = h;
      6: v = (h >= 32768) ? h - 65536 : h;
      default: v = 0;
    endcase
    r.e = (op == 7) || (op >= 5 && (off % 2) == 1);
    if (r.e) v = 0;
    r.d = 32'(v);
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(q[0].d));
        chk("out_err", 64'(out_err), 64'(q[0].e));
      end
      chk("err_cnt", 64'(err_cnt), 64'((ecnt > 65535) ? 65535 : ecnt));
      chk("sat_err_cnt", 64'(err_cnt_s), 64'((ecnt > 3) ? 3 : ecnt));
      chk("sat_out_valid", 64'(out_valid_s), 64'(q.size() > 0));
    end
    acc = in_valid && (q.size() < 2);
    del = (q.size() > 0) && out_ready;
    nb  = ref_ext(int'(in_op), int'(in_imm), longint'(in_data), int'(in_off));
    if (reset) begin
      q.delete();
      ecnt = 0;
    end else begin
      if (del) begin
        if (q[0].e) ecnt++;
        n_deliv++;
        void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (acc) q.push_back(nb);
    end
  end

  task automatic rst_check(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_out_err"}, 64'(out_err), 64'd0);
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'd0);
    chk({tag, "_sat_cnt"}, 64'(err_cnt_s), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    rst_check(tag);
  endtask

  task automatic send(input int op, input logic [15:0] imm, input logic [31:0] d,
                      input int off, input logic [31:0] ed, input logic ee, input string nm);
    @(posedge clk); #1;
    in_valid  = 1'b1;
    in_op     = 3'(op);
    in_imm    = imm;
    in_data   = d;
    in_off    = 2'(off);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, 64'(out_valid), 64'd1);
    chk({nm, "_data"}, 64'(out_data), 64'(ed));
    chk({nm, "_err"}, 64'(out_err), 64'(ee));
  endtask

  initial begin
    int acc_n, base;
    bit saw_stall;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_imm = '0; in_data = '0; in_off = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    do_reset("rst0");

    send(1, 16'h8000, 32'h0, 0, 32'hFFFF8000, 1'b0, "se");
    send(2, 16'h1234, 32'h0, 0, 32'h12340000, 1'b0, "he");
    send(4, 16'h0, 32'h12F45678, 2, 32'hFFFFFFF4, 1'b0, "lb");
    send(5, 16'h0, 32'h12F45678, 2, 32'h000012F4, 1'b0, "lhu");
    send(6, 16'h0, 32'h12F45678, 1, 32'h0, 1'b1, "lh_mis");
    send(7, 16'hFFFF, 32'hFFFFFFFF, 0, 32'h0, 1'b1, "rsv");
    chk("cnt_after_lh", 64'(err_cnt), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cnt_after_rsv", 64'(err_cnt), 64'd2);

    // Four-beat stream with the consumer stalled for two cycles.
    acc_n = 0; saw_stall = 0; base = n_deliv;
    @(posedge clk); #1;
    for (int c = 0; c < 12; c++) begin
      in_valid  = (acc_n < 4);
      in_op     = 3'd0;
      in_imm    = 16'(100 + acc_n);
      out_ready = !(c == 1 || c == 2);
      if (!in_ready) saw_stall = 1;
      if (in_valid && in_ready) acc_n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_stall", 64'(saw_stall), 64'd1);
    chk("stream_deliv", 64'(n_deliv - base), 64'd4);

    // Flush with one and then two beats held, while another beat is offered.
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      in_valid = 1'b1;
      for (int j = 0; j < k; j++) begin
        in_imm = 16'(j + 1);
        @(posedge clk); #1;
      end
      flush = 1'b1;
      in_imm = 16'hDEAD;
      @(posedge clk); #1;
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_in_ready", 64'(in_ready), 64'd1);
      repeat (3) @(posedge clk);
    end

    do_reset("rst1");
    for (int i = 0; i < 5; i++) send(7, 16'h0, 32'h0, 0, 32'h0, 1'b1, "sat_beat");
    @(posedge clk); #1;
    @(negedge clk);
    chk("sat_cnt3", 64'(err_cnt_s), 64'd3);
    chk("main_cnt5", 64'(err_cnt), 64'd5);

    // Reset while both registers are full and a beat is offered.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_op = 3'd7;
    repeat (2) begin
      @(posedge clk); #1;
    end
    do_reset("rst_full");

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      in_op     = 3'($urandom);
      in_imm    = 16'($urandom);
      in_data   = $urandom;
      in_off    = 2'($urandom);
      @(posedge clk); #1;
    end
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
